// File: rtl/ts_write_scheduler.sv
// ts_write_scheduler: FIFO-buffered, busy-paced write replay for a TurboSound-FM pair of YM2203s.
// Define TS_DUAL_EN for two chips; otherwise chip-select entries are consumed in order but ignored.
module ts_write_scheduler #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_WAIT = 17,
    parameter int unsigned DATA_WAIT = 83,
    parameter int unsigned PSG_WAIT  = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE_YM,
    input  logic       FM_ENA,
    input  logic       CPU_WR,
    input  logic       CPU_RD,
    input  logic       CPU_A0,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_WAIT,
    output logic [1:0] YM_WE,
    output logic       YM_A0,
    output logic [7:0] YM_DO,
    input  logic [7:0] YM_DI0,
    input  logic [7:0] YM_DI1,
    output logic       YM_SEL,
    output logic       OVERFLOW
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef TS_DUAL_EN
    localparam int unsigned NCHIP = 2;
`else
    localparam int unsigned NCHIP = 1;
`endif
    localparam logic [7:0] ADDR_W8 = 8'(ADDR_WAIT);
    localparam logic [7:0] DATA_W8 = 8'(DATA_WAIT);
    localparam logic [7:0] PSG_W8  = 8'(PSG_WAIT);

    typedef enum logic [1:0] {K_ADR = 2'd0, K_DAT = 2'd1, K_SEL = 2'd2} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [7:0] data;
    } entry_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_HOLD = 2'd2} state_e;

    entry_t           mem_q [DEPTH];
    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           cur_q, cur_d, push_entry;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [7:0]       shadow_q [NCHIP];
    logic [7:0]       shadow_d [NCHIP];
    logic             sel_q, sel_d;
    logic [1:0]       ym_we_q, ym_we_d;
    logic             ym_a0_q, ym_a0_d;
    logic [7:0]       ym_do_q, ym_do_d;
    logic [7:0]       cpu_do_q, cpu_do_d;
    logic             cpu_wait_q, cpu_wait_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, rd_busy;
    logic [7:0]       cur_shadow, rd_data;

`ifdef TS_DUAL_EN
    assign cur_shadow = shadow_q[sel_q];
    assign rd_data    = sel_q ? YM_DI1 : YM_DI0;
`else
    logic unused_di1;
    assign cur_shadow = shadow_q[0];
    assign rd_data    = YM_DI0;
    assign unused_di1 = ^YM_DI1;
`endif

    // Classify the incoming CPU write into a FIFO entry
    always_comb begin
        push_entry.data = CPU_DI;
        if (CPU_A0)
            push_entry.kind = K_DAT;
        else if (FM_ENA && (CPU_DI[7:1] == 7'h7F))
            push_entry.kind = K_SEL;
        else
            push_entry.kind = K_ADR;
    end

    assign push    = CPU_WR && (count_q != CNT_W'(DEPTH));
    assign pop     = (state_q == S_IDLE) && (count_q != '0);
    assign rd_busy = (count_q != '0) || (state_q != S_IDLE);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cur_d      = cur_q;
        wcnt_d     = wcnt_q;
        shadow_d   = shadow_q;
        sel_d      = sel_q;
        ym_we_d    = 2'b00;
        ym_a0_d    = ym_a0_q;
        ym_do_d    = ym_do_q;
        cpu_do_d   = cpu_do_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (CPU_WR && !push) overflow_d = 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_d    = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_ISSUE;
                    // Strobe goes out with the pop so the chip sees it during ISSUE
                    if (mem_q[rd_ptr_q].kind != K_SEL) begin
                        ym_we_d[sel_q] = 1'b1;
                        ym_a0_d        = (mem_q[rd_ptr_q].kind == K_DAT);
                        ym_do_d        = mem_q[rd_ptr_q].data;
                    end
                end
            end
            S_ISSUE: begin
                if (cur_q.kind == K_SEL) begin
`ifdef TS_DUAL_EN
                    sel_d = ~cur_q.data[0];
`endif
                    state_d = S_IDLE;
                end else begin
                    if (cur_q.kind == K_ADR) begin
`ifdef TS_DUAL_EN
                        shadow_d[sel_q] = cur_q.data;
`else
                        shadow_d[0] = cur_q.data;
`endif
                        wcnt_d = ADDR_W8;
                    end else begin
                        wcnt_d = (cur_shadow < 8'h10) ? PSG_W8 : DATA_W8;
                    end
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wcnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else if (CE_YM) begin
                    wcnt_d = wcnt_q - 8'd1;
                    if (wcnt_q == 8'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (CPU_RD && !rd_busy) cpu_do_d = rd_data;
        cpu_wait_d = (count_d >= CNT_W'(DEPTH - 1)) || (CPU_RD && rd_busy);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cur_q      <= '0;
            wcnt_q     <= '0;
            for (int i = 0; i < NCHIP; i++) shadow_q[i] <= '0;
            sel_q      <= 1'b0;
            ym_we_q    <= 2'b00;
            ym_a0_q    <= 1'b0;
            ym_do_q    <= '0;
            cpu_do_q   <= '0;
            cpu_wait_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            wcnt_q     <= wcnt_d;
            shadow_q   <= shadow_d;
            sel_q      <= sel_d;
            ym_we_q    <= ym_we_d;
            ym_a0_q    <= ym_a0_d;
            ym_do_q    <= ym_do_d;
            cpu_do_q   <= cpu_do_d;
            cpu_wait_q <= cpu_wait_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign YM_WE    = ym_we_q;
    assign YM_A0    = ym_a0_q;
    assign YM_DO    = ym_do_q;
    assign YM_SEL   = sel_q;
    assign CPU_DO   = cpu_do_q;
    assign CPU_WAIT = cpu_wait_q;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_ts_write_scheduler.sv
// Bench for ts_write_scheduler: scoreboard of expected chip writes plus directed timing checks.
// Honours TS_DUAL_EN the same way as the design.
module tb_ts_write_scheduler;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ADDR_WAIT = 17;
    localparam int unsigned DATA_WAIT = 83;
    localparam int unsigned PSG_WAIT  = 2;
`ifdef TS_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N, CE_YM, FM_ENA, CPU_WR, CPU_RD, CPU_A0;
    logic [7:0] CPU_DI, CPU_DO, YM_DO, YM_DI0, YM_DI1;
    logic       CPU_WAIT, YM_A0, YM_SEL, OVERFLOW;
    logic [1:0] YM_WE;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         t0;
    int         n;
    bit         mdl_sel = 1'b0;
    logic [10:0] exp_q [$];
    int          pulses [$];

    ts_write_scheduler #(
        .DEPTH(DEPTH), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT), .PSG_WAIT(PSG_WAIT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE_YM(CE_YM), .FM_ENA(FM_ENA),
        .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_A0(CPU_A0), .CPU_DI(CPU_DI),
        .CPU_DO(CPU_DO), .CPU_WAIT(CPU_WAIT), .YM_WE(YM_WE), .YM_A0(YM_A0),
        .YM_DO(YM_DO), .YM_DI0(YM_DI0), .YM_DI1(YM_DI1), .YM_SEL(YM_SEL),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, score any chip write strobe
    task automatic tick();
        logic [10:0] e;
        @(posedge CLK);
        #1;
        cyc++;
        if (YM_WE != 2'b00) begin
            e = 11'h000;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            pulses.push_back(cyc);
            check("ym_write", 32'({YM_WE, YM_A0, YM_DO}), 32'(e));
        end
    endtask

    task automatic wr(input logic a0, input logic [7:0] di);
        if (!a0 && FM_ENA && (di == 8'hFF || di == 8'hFE))
            mdl_sel = DUAL && (di == 8'hFE);
        else
            exp_q.push_back({(mdl_sel ? 2'b10 : 2'b01), a0, di});
        CPU_WR = 1'b1; CPU_A0 = a0; CPU_DI = di;
        tick();
        CPU_WR = 1'b0;
    endtask

    task automatic wr_drop(input logic a0, input logic [7:0] di);
        CPU_WR = 1'b1; CPU_A0 = a0; CPU_DI = di;
        tick();
        CPU_WR = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (DATA_WAIT + 4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; CE_YM = 1'b0; FM_ENA = 1'b1; CPU_WR = 1'b0; CPU_RD = 1'b0;
        CPU_A0 = 1'b0; CPU_DI = 8'h00; YM_DI0 = 8'h00; YM_DI1 = 8'h00;
        repeat (3) tick();
        check("rst_ym_we",    32'(YM_WE),    32'd0);
        check("rst_ym_a0",    32'(YM_A0),    32'd0);
        check("rst_ym_do",    32'(YM_DO),    32'd0);
        check("rst_cpu_do",   32'(CPU_DO),   32'd0);
        check("rst_cpu_wait", 32'(CPU_WAIT), 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        check("rst_ym_sel",   32'(YM_SEL),   32'd0);
        RESET_N = 1'b1; CE_YM = 1'b1;
        tick();

        // Address, FM data, FM data: latency and hold spacing (ISSUE + IDLE add 2 clocks)
        pulses.delete();
        t0 = cyc;
        wr(1'b0, 8'h28); wr(1'b1, 8'hF0); wr(1'b1, 8'hF1);
        drain(400);
        check("t1_pulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("t1_latency",  32'(pulses[0] - t0),        32'd2);
            check("t1_gap_addr", 32'(pulses[1] - pulses[0]), 32'(ADDR_WAIT + 2));
            check("t1_gap_fm",   32'(pulses[2] - pulses[1]), 32'(DATA_WAIT + 2));
        end

        // Chip select, PSG address then two PSG data writes
        pulses.delete();
        wr(1'b0, 8'hFE); wr(1'b0, 8'h07); wr(1'b1, 8'h3F); wr(1'b1, 8'h11);
        drain(200);
        check("t2_sel", 32'(YM_SEL), 32'(DUAL));
        check("t2_pulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("t2_gap_addr", 32'(pulses[1] - pulses[0]), 32'(ADDR_WAIT + 2));
            check("t2_gap_psg",  32'(pulses[2] - pulses[1]), 32'(PSG_WAIT + 2));
        end
        FM_ENA = 1'b0;
        wr(1'b0, 8'hFE);
        FM_ENA = 1'b1;
        drain(100);

        // Read with three entries queued on the currently selected chip
        YM_DI0 = 8'hC3; YM_DI1 = 8'h5A;
        wr(1'b0, 8'h08); wr(1'b1, 8'h0A); wr(1'b0, 8'h09);
        CPU_RD = 1'b1;
        tick();
        check("rd_wait_busy", 32'(CPU_WAIT), 32'd1);
        n = 0;
        while (CPU_WAIT && n < 400) begin tick(); n++; end
        check("rd_wait_drop", 32'(CPU_WAIT), 32'd0);
        check("rd_data_sel",  32'(CPU_DO), DUAL ? 32'h5A : 32'hC3);
        check("rd_drained",   32'(exp_q.size()), 32'd0);
        CPU_RD = 1'b0;
        wr(1'b0, 8'hFF);
        drain(50);
        YM_DI0 = 8'h5A; YM_DI1 = 8'hA5;
        CPU_RD = 1'b1;
        tick();
        check("rd0_wait", 32'(CPU_WAIT), 32'd0);
        check("rd0_data", 32'(CPU_DO), 32'h5A);
        CPU_RD = 1'b0;
        tick();

        // Fill with CE_YM stopped: wait at count 7, ninth write dropped
        CE_YM = 1'b0;
        wr(1'b0, 8'h30);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) wr(1'b1, 8'(8'h40 + i));
            else       wr_drop(1'b1, 8'h48);
            if (i == 5) check("full_wait_c6", 32'(CPU_WAIT), 32'd0);
            if (i == 6) check("full_wait_c7", 32'(CPU_WAIT), 32'd1);
            if (i == 7) check("ovf_c8",       32'(OVERFLOW), 32'd0);
            if (i == 8) check("ovf_drop",     32'(OVERFLOW), 32'd1);
        end
        CE_YM = 1'b1;
        drain(9 * (DATA_WAIT + 4));
        check("ovf_sticky",    32'(OVERFLOW), 32'd1);
        check("wait_after_ff", 32'(CPU_WAIT), 32'd0);

        // Push in the same clock as a pop at count 4
        CE_YM = 1'b0;
        wr(1'b0, 8'h2A);
        wr(1'b1, 8'h50); wr(1'b0, 8'h12); wr(1'b1, 8'h51); wr(1'b1, 8'h52);
        CE_YM = 1'b1;
        repeat (ADDR_WAIT) tick();
        CE_YM = 1'b0;
        wr(1'b1, 8'h53);
        wr(1'b1, 8'h54); wr(1'b1, 8'h55);
        check("pp_wait_c6", 32'(CPU_WAIT), 32'd0);
        wr(1'b1, 8'h56);
        check("pp_wait_c7", 32'(CPU_WAIT), 32'd1);
        CE_YM = 1'b1;
        drain(8 * (DATA_WAIT + 4));

        // Asynchronous reset in the middle of an FM data hold
        wr(1'b0, 8'hFE); wr(1'b0, 8'h2B); wr(1'b1, 8'hC0); wr(1'b1, 8'hC1);
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin tick(); n++; end
        check("pre_rst_c0", 32'(exp_q.size()), 32'd1);
        repeat (5) tick();
        #2 RESET_N = 1'b0;
        #1;
        check("arst_ym_we",    32'(YM_WE),    32'd0);
        check("arst_ym_a0",    32'(YM_A0),    32'd0);
        check("arst_ym_do",    32'(YM_DO),    32'd0);
        check("arst_cpu_do",   32'(CPU_DO),   32'd0);
        check("arst_cpu_wait", 32'(CPU_WAIT), 32'd0);
        check("arst_overflow", 32'(OVERFLOW), 32'd0);
        check("arst_ym_sel",   32'(YM_SEL),   32'd0);
        exp_q.delete();
        mdl_sel = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        pulses.delete();
        repeat (40) tick();
        check("post_rst_quiet", 32'(pulses.size()), 32'd0);
        check("post_rst_sel",   32'(YM_SEL), 32'd0);
        t0 = cyc;
        wr(1'b0, 8'h33);
        tick(); tick();
        check("post_rst_pulses", 32'(pulses.size()), 32'd1);
        if (pulses.size() == 1) check("post_rst_latency", 32'(pulses[0] - t0), 32'd2);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
